muldiv_sequencer: RTL and testbench

//  Execute-stage controller for the multicycle MUL/DIV units. Accepts one M-extension op from the

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_sequencer.sv | 113 +++++++++++
 tb/tb_muldiv_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op decode, sequencer state encoding and helpers shared by the MUL/DIV sequencer.
package muldiv_pkg;

    typedef enum logic [4:0] {
        OP_NONE, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
    } op_t;

    typedef enum logic [2:0] {S_IDLE, S_RUN_MUL, S_RUN_DIV, S_HOLD, S_DRAIN} seq_state_t;

    localparam int CNT_W = 9;

    function automatic logic is_mul_op(op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW};
    endfunction

    function automatic logic is_div_op(op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: issues one M op to the multiplier or divider, holds the result for the
// downstream handshake, and drains a flushed unit to completion since units cannot abort.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  op_t         req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic        req_ready,
    input  logic        flush,
    output logic        mul_valid,
    output op_t         mul_op,
    output logic [63:0] mul_a,
    output logic [63:0] mul_b,
    input  logic        mul_done,
    input  logic [63:0] mul_c,
    output logic        div_valid,
    output op_t         div_op,
    output logic [63:0] div_a,
    output logic [63:0] div_b,
    input  logic        div_done,
    input  logic [63:0] div_c,
    output logic        resp_valid,
    output logic [63:0] resp_data,
    input  logic        resp_ready,
    output logic        stall,
    output logic        err_timeout
);

    seq_state_t       state, nxt;
    op_t              op_q;
    logic [63:0]      a_q, b_q, res_q;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic             run, busy, accept, unit_done, wd_hit, timeout;

    assign run       = state == S_RUN_MUL || state == S_RUN_DIV;
    assign busy      = run || state == S_DRAIN;
    assign accept    = state == S_IDLE && req_valid && !flush && (is_mul_op(req_op) || is_div_op(req_op));
    // op_q always names the unit owning the current RUN/DRAIN, so its done is the only one heeded
    assign unit_done = is_mul_op(op_q) ? mul_done : div_done;
    assign wd_hit    = TIMEOUT_CYC != 0 && busy && cnt == CNT_W'(TIMEOUT_CYC - 1);
    assign timeout   = wd_hit && !unit_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) nxt = is_mul_op(req_op) ? S_RUN_MUL : S_RUN_DIV;
            end
            S_RUN_MUL, S_RUN_DIV: begin
                if (unit_done)    nxt = flush ? S_IDLE : S_HOLD;
                else if (timeout) nxt = S_IDLE;
                else if (flush)   nxt = S_DRAIN;
            end
            S_HOLD: begin
                if (resp_ready || flush) nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (unit_done || timeout) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = state == S_IDLE;
        mul_valid   = state == S_RUN_MUL || (state == S_DRAIN && is_mul_op(op_q));
        div_valid   = state == S_RUN_DIV || (state == S_DRAIN && is_div_op(op_q));
        resp_valid  = state == S_HOLD;
        stall       = (req_valid && state != S_IDLE) || busy;
        mul_op      = op_q;
        mul_a       = a_q;
        mul_b       = b_q;
        div_op      = op_q;
        div_a       = a_q;
        div_b       = b_q;
        resp_data   = res_q;
        err_timeout = err_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q  <= OP_NONE;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= req_op;
                a_q  <= req_a;
                b_q  <= req_b;
            end
            if (run && unit_done && !flush) res_q <= is_mul_op(op_q) ? mul_c : div_c;
            if (accept)                     cnt <= '0;
            else if (busy && cnt != '1)     cnt <= cnt + 1'b1;
            if (timeout)                    err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: random and directed ops against behavioural MUL/DIV unit models;
// expected results are queued at issue and compared by an independent response monitor.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int TMO = 100;

    logic        clk = 0, reset = 0, req_valid = 0, flush = 0, resp_ready = 0;
    logic        mul_done = 0, div_done = 0;
    op_t         req_op = OP_NONE;
    logic [63:0] req_a = 0, req_b = 0, mul_c = 0, div_c = 0;
    logic        req_ready, mul_valid, div_valid, resp_valid, stall, err_timeout;
    op_t         mul_op, div_op;
    logic [63:0] mul_a, mul_b, div_a, div_b, resp_data;

    int          errors = 0, checks = 0;
    logic [63:0] exp_q[$];
    int          mul_lat = 1, div_lat = 1, mcnt = 0, dcnt = 0;
    bit          mul_hang = 0, div_hang = 0, mfired = 0, dfired = 0;

    muldiv_sequencer #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_a(req_a),
        .req_b(req_b), .req_ready(req_ready), .flush(flush), .mul_valid(mul_valid),
        .mul_op(mul_op), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_c(mul_c),
        .div_valid(div_valid), .div_op(div_op), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_c(div_c), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_ready(resp_ready), .stall(stall), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sx32(logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    // RISC-V M-extension semantics, including divide-by-zero and signed overflow results
    function automatic logic [63:0] ref_result(op_t op, logic [63:0] a, logic [63:0] b);
        logic signed [127:0] sa, sb, ub, p;
        logic [127:0]        pu;
        logic signed [63:0]  q;
        logic signed [31:0]  q32;
        logic [31:0]         a32, b32;
        logic                ovf, ovf32;
        sa = $signed(a); sb = $signed(b); ub = {64'b0, b};
        a32 = a[31:0]; b32 = b[31:0];
        ovf = a == 64'h8000_0000_0000_0000 && b == '1;
        ovf32 = a32 == 32'h8000_0000 && b32 == '1;
        case (op)
            OP_MUL:    return a * b;
            OP_MULH:   begin p = sa * sb; return p[127:64]; end
            OP_MULHSU: begin p = sa * ub; return p[127:64]; end
            OP_MULHU:  begin pu = {64'b0, a} * {64'b0, b}; return pu[127:64]; end
            OP_MULW:   return sx32(a32 * b32);
            OP_DIV:    begin if (b == 0) return '1; if (ovf) return a; q = $signed(a) / $signed(b); return q; end
            OP_DIVU:   return b == 0 ? '1 : a / b;
            OP_REM:    begin if (b == 0) return a; if (ovf) return 0; q = $signed(a) % $signed(b); return q; end
            OP_REMU:   return b == 0 ? a : a % b;
            OP_DIVW:   begin if (b32 == 0) return '1; if (ovf32) return sx32(a32); q32 = $signed(a32) / $signed(b32); return sx32(q32); end
            OP_DIVUW:  return b32 == 0 ? '1 : sx32(a32 / b32);
            OP_REMW:   begin if (b32 == 0) return sx32(a32); if (ovf32) return 0; q32 = $signed(a32) % $signed(b32); return sx32(q32); end
            OP_REMUW:  return b32 == 0 ? sx32(a32) : sx32(a32 % b32);
            default:   return 0;
        endcase
    endfunction

    // unit models: answer once, mul_lat/div_lat valid cycles after valid rises, from presented operands
    initial forever begin
        @(negedge clk);
        if (!mul_valid) begin mcnt = 0; mfired = 0; mul_done = 0; end
        else begin
            mcnt++;
            mul_done = !mfired && !mul_hang && mcnt >= mul_lat;
            if (mul_done) begin mfired = 1; mul_c = ref_result(mul_op, mul_a, mul_b); end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!div_valid) begin dcnt = 0; dfired = 0; div_done = 0; end
        else begin
            dcnt++;
            div_done = !dfired && !div_hang && dcnt >= div_lat;
            if (div_done) begin dfired = 1; div_c = ref_result(div_op, div_a, div_b); end
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset && resp_valid && resp_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp_unexpected: got %0h expected no response", resp_data);
            end else chk("resp_data", resp_data, exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(op_t op, logic [63:0] a, logic [63:0] b);
        int w = 0;
        while (!req_ready && w < 300) begin step(); w++; end
        chk("issue_ready", req_ready, 1);
        req_valid = 1; req_op = op; req_a = a; req_b = b;
        if (op != OP_NONE) exp_q.push_back(ref_result(op, a, b));
        step();
        req_valid = 0;
    endtask

    task automatic wait_resp(output int n);
        n = 1;
        while (!resp_valid && n < 400) begin step(); n++; end
    endtask

    initial begin
        int n, bad, seen, sel;
        logic [63:0] a, b;
        op_t op;
        #3;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_valids", {mul_valid, div_valid, resp_valid, err_timeout}, 0);
        chk("rst_regs", resp_data | mul_a | div_b, 0);
        step(); reset = 1; step();

        div_lat = 65; resp_ready = 1;
        issue(OP_DIVU, 100, 7);
        n = 1; bad = 0;
        while (!resp_valid && n < 400) begin
            if (div_valid && !stall) bad++;
            step(); n++;
        end
        chk("t1_latency", n, 66);
        chk("t1_stall_run", bad, 0);
        chk("t1_data", resp_data, 14);
        step();
        chk("t1_once", resp_valid, 0);
        chk("t1_idle", req_ready, 1);

        div_lat = 1;
        issue(OP_DIV, 123, 0);
        wait_resp(n);
        chk("t2_latency", n, 2);
        chk("t2_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        step();

        resp_ready = 0; mul_lat = 3;
        issue(OP_MUL, 3, 5);
        wait_resp(n);
        chk("t3_latency", n, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_valid", resp_valid, 1);
            chk("t3_hold_data", resp_data, 15);
            chk("t3_hold_ready", req_ready, 0);
            step();
        end
        resp_ready = 1;
        step();
        chk("t3_idle", {req_ready, resp_valid}, 2'b10);

        issue(OP_NONE, 1, 2);
        chk("nonm_ignored", {req_ready, mul_valid, div_valid}, 3'b100);

        div_lat = 30;
        issue(OP_REM, 50, 7);
        repeat (9) step();
        flush = 1;
        step();
        flush = 0;
        void'(exp_q.pop_back());
        chk("t4_drain", {req_ready, stall, div_valid}, 3'b011);
        n = 11; seen = 0;
        while (div_valid && n < 400) begin
            if (resp_valid) seen++;
            step(); n++;
        end
        chk("t4_drop_cycle", n, 31);
        chk("t4_ready", req_ready, 1);
        chk("t4_no_resp", seen, 0);

        div_lat = 5;
        issue(OP_DIVU, 9, 3);
        repeat (4) step();
        flush = 1;
        step();
        flush = 0;
        void'(exp_q.pop_back());
        chk("flush_done", {req_ready, resp_valid, div_valid}, 3'b100);

        resp_ready = 0; mul_lat = 2;
        issue(OP_MULHU, {$urandom, $urandom}, {$urandom, $urandom});
        wait_resp(n);
        chk("flush_hold_lat", n, 3);
        flush = 1;
        void'(exp_q.pop_back());
        step();
        flush = 0;
        chk("flush_hold", {req_ready, resp_valid}, 2'b10);
        resp_ready = 1;

        div_hang = 1;
        issue(OP_DIV, 7, 3);
        n = 1;
        while (!err_timeout && n < 400) begin step(); n++; end
        chk("t5_timeout_cycle", n, TMO + 1);
        chk("t5_state", {req_ready, div_valid}, 2'b10);
        void'(exp_q.pop_back());
        div_hang = 0; mul_lat = 2;
        issue(OP_MUL, 6, 7);
        wait_resp(n);
        step();
        chk("t5_sticky", err_timeout, 1);

        mul_lat = 50;
        issue(OP_MUL, 11, 13);
        repeat (3) step();
        #2 reset = 0;
        #1;
        chk("t6_async", {mul_valid, req_ready, stall, err_timeout, resp_valid}, 5'b01000);
        chk("t6_regs", mul_a | mul_b, 0);
        void'(exp_q.pop_back());
        step(); reset = 1; step();
        mul_lat = 4;
        issue(OP_MULW, {$urandom, $urandom}, {$urandom, $urandom});
        wait_resp(n);
        chk("t6_mulw_latency", n, 5);
        step();

        repeat (40) begin
            op = op_t'($urandom_range(0, 13));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            sel = $urandom_range(0, 5);
            if (sel == 0) b = 0;
            if (sel == 1) begin a = $urandom_range(0, 1) ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_8000_0000; b = '1; end
            if (sel == 2) b = $urandom_range(1, 20);
            mul_lat = $urandom_range(1, 8);
            div_lat = $urandom_range(1, 8);
            issue(op, a, b);
            n = 0;
            while (!req_ready && n < 200) begin
                resp_ready = $urandom_range(0, 1);
                step(); n++;
            end
            chk("rnd_back_idle", req_ready, 1);
        end
        resp_ready = 1;
        repeat (3) step();
        chk("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
